// File: rtl/tx_stream_sequencer.sv
// Packetised incrementing-pattern source feeding the MAC TX AXI-stream input.
// Optional build macro TX_STREAM_SEQ_STATS_EN adds saturating pkt_count/word_count outputs.
module tx_stream_sequencer #(
    parameter int DATA_W  = 32,
    parameter int LEN_W   = 16,
    parameter int CNT_W   = 16,
    parameter int PAUSE_W = 32
) (
    input  logic               clk,
    input  logic               glbl_rst,
    input  logic               start,
    input  logic               stop,
    input  logic [LEN_W-1:0]   pkt_words,
    input  logic [CNT_W-1:0]   pkts_per_burst,
    input  logic [PAUSE_W-1:0] pause_cycles,
    output logic               tx_valid,
    input  logic               tx_ready,
    output logic [DATA_W-1:0]  tx_data,
    output logic               tx_last,
    output logic               busy,
    output logic               burst_done
`ifdef TX_STREAM_SEQ_STATS_EN
    ,
    output logic [31:0]        pkt_count,
    output logic [31:0]        word_count
`endif
);

    typedef enum logic [1:0] {IDLE = 2'd0, SEND = 2'd1, PAUSE = 2'd2} state_t;

    state_t             state_reg, state_next;
    logic [LEN_W-1:0]   word_idx_reg, word_idx_next;
    logic [CNT_W-1:0]   pkt_idx_reg, pkt_idx_next;
    logic [PAUSE_W-1:0] pause_cnt_reg, pause_cnt_next;
    logic [LEN_W-1:0]   pkt_words_l_reg, pkt_words_l_next;
    logic [CNT_W-1:0]   pkts_l_reg, pkts_l_next;
    logic [PAUSE_W-1:0] pause_l_reg, pause_l_next;
    logic [DATA_W-1:0]  data_reg, data_next;
    logic               stop_pend_reg, stop_pend_next;
    logic               valid_reg, valid_next;
    logic               last_reg, last_next;
    logic               busy_reg, busy_next;
    logic               burst_done_reg, burst_done_next;

    logic cfg_ok, launch, hs, last_hs, pkt_final, burst_end, enter_send;

    assign cfg_ok     = (pkt_words != '0) && (pkts_per_burst != '0);
    assign launch     = start && !stop && cfg_ok;
    assign hs         = valid_reg && tx_ready;
    assign last_hs    = hs && last_reg;
    assign pkt_final  = (pkt_idx_reg == pkts_l_reg - CNT_W'(1));
    assign burst_end  = last_hs && !stop_pend_reg && pkt_final;
    // A SEND->SEND transition only happens when a finished burst relaunches.
    assign enter_send = (state_next == SEND) && ((state_reg != SEND) || burst_end);

    always_ff @(posedge clk) begin
        if (glbl_rst) begin
            state_reg       <= IDLE;
            word_idx_reg    <= '0;
            pkt_idx_reg     <= '0;
            pause_cnt_reg   <= '0;
            pkt_words_l_reg <= '0;
            pkts_l_reg      <= '0;
            pause_l_reg     <= '0;
            data_reg        <= '0;
            stop_pend_reg   <= 1'b0;
            valid_reg       <= 1'b0;
            last_reg        <= 1'b0;
            busy_reg        <= 1'b0;
            burst_done_reg  <= 1'b0;
        end else begin
            state_reg       <= state_next;
            word_idx_reg    <= word_idx_next;
            pkt_idx_reg     <= pkt_idx_next;
            pause_cnt_reg   <= pause_cnt_next;
            pkt_words_l_reg <= pkt_words_l_next;
            pkts_l_reg      <= pkts_l_next;
            pause_l_reg     <= pause_l_next;
            data_reg        <= data_next;
            stop_pend_reg   <= stop_pend_next;
            valid_reg       <= valid_next;
            last_reg        <= last_next;
            busy_reg        <= busy_next;
            burst_done_reg  <= burst_done_next;
        end
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE: begin
                if (launch) state_next = SEND;
            end
            SEND: begin
                if (last_hs) begin
                    if (stop_pend_reg)           state_next = IDLE;
                    else if (pkt_final) begin
                        if (pause_l_reg != '0)   state_next = PAUSE;
                        else if (launch)         state_next = SEND;
                        else                     state_next = IDLE;
                    end
                end
            end
            PAUSE: begin
                if (stop_pend_reg || stop)                  state_next = IDLE;
                else if (pause_cnt_reg == PAUSE_W'(1))      state_next = launch ? SEND : IDLE;
            end
            default: state_next = IDLE;
        endcase
    end

    always_comb begin
        data_next        = hs ? data_reg + DATA_W'(1) : data_reg;
        pkt_words_l_next = enter_send ? pkt_words      : pkt_words_l_reg;
        pkts_l_next      = enter_send ? pkts_per_burst : pkts_l_reg;
        pause_l_next     = enter_send ? pause_cycles   : pause_l_reg;

        word_idx_next = word_idx_reg;
        if (last_hs)  word_idx_next = '0;
        else if (hs)  word_idx_next = word_idx_reg + LEN_W'(1);

        pkt_idx_next = pkt_idx_reg;
        if (state_next != SEND || enter_send) pkt_idx_next = '0;
        else if (last_hs)                     pkt_idx_next = pkt_idx_reg + CNT_W'(1);

        // Counter runs pause_l..1, giving exactly pause_l idle cycles.
        pause_cnt_next = '0;
        if (state_next == PAUSE)
            pause_cnt_next = (state_reg == PAUSE) ? pause_cnt_reg - PAUSE_W'(1) : pause_l_reg;

        stop_pend_next  = (state_reg == IDLE) ? 1'b0 : (stop_pend_reg || stop);
        valid_next      = (state_next == SEND);
        busy_next       = (state_next != IDLE);
        burst_done_next = burst_end;
        last_next       = (state_next == SEND) &&
                          (word_idx_next == pkt_words_l_next - LEN_W'(1));
    end

    always_comb begin
        tx_valid   = valid_reg;
        tx_data    = data_reg;
        tx_last    = last_reg;
        busy       = busy_reg;
        burst_done = burst_done_reg;
    end

`ifdef TX_STREAM_SEQ_STATS_EN
    logic [31:0] pkt_count_reg, word_count_reg;

    always_ff @(posedge clk) begin
        if (glbl_rst) begin
            pkt_count_reg  <= '0;
            word_count_reg <= '0;
        end else begin
            if (hs && word_count_reg != '1)     word_count_reg <= word_count_reg + 32'd1;
            if (last_hs && pkt_count_reg != '1) pkt_count_reg  <= pkt_count_reg + 32'd1;
        end
    end

    assign pkt_count  = pkt_count_reg;
    assign word_count = word_count_reg;
`endif

endmodule

// File: tb/tb_tx_stream_sequencer.sv
// Scoreboard bench for tx_stream_sequencer: expected beats come from a burst-level model.
module tb_tx_stream_sequencer;
    localparam int DATA_W = 32, LEN_W = 16, CNT_W = 16, PAUSE_W = 32;

    logic               clk = 1'b0;
    logic               glbl_rst = 1'b1;
    logic               start = 1'b0;
    logic               stop = 1'b0;
    logic [LEN_W-1:0]   pkt_words = '0;
    logic [CNT_W-1:0]   pkts_per_burst = '0;
    logic [PAUSE_W-1:0] pause_cycles = '0;
    logic               tx_valid, tx_last, busy, burst_done;
    logic               tx_ready = 1'b1;
    logic [DATA_W-1:0]  tx_data;
`ifdef TX_STREAM_SEQ_STATS_EN
    logic [31:0]        pkt_count, word_count;
`endif

    tx_stream_sequencer #(.DATA_W(DATA_W), .LEN_W(LEN_W), .CNT_W(CNT_W), .PAUSE_W(PAUSE_W)) dut (
        .clk(clk), .glbl_rst(glbl_rst), .start(start), .stop(stop),
        .pkt_words(pkt_words), .pkts_per_burst(pkts_per_burst), .pause_cycles(pause_cycles),
        .tx_valid(tx_valid), .tx_ready(tx_ready), .tx_data(tx_data), .tx_last(tx_last),
        .busy(busy), .burst_done(burst_done)
`ifdef TX_STREAM_SEQ_STATS_EN
        , .pkt_count(pkt_count), .word_count(word_count)
`endif
    );

    always #5 clk = ~clk;

    typedef struct packed { logic [31:0] data; logic last; } beat_t;

    int          errors = 0, checks = 0;
    int          cyc = 0, beats_seen = 0, bd_seen = 0, bd_cyc = 0, idle_cyc = 0;
    int          ready_mode = 0;
    int          hs_cyc[int];
    beat_t       exp_q[$];
    beat_t       mon_e;
    logic [31:0] exp_data = '0;
    int          exp_bd = 0;
    longint      exp_pkts = 0, exp_words = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0d required %0d", name, act, exp);
        end
    endtask

    // Ready driver: 0 = always ready, 1 = alternating, 2 = random.
    always begin
        @(posedge clk);
        #1;
        case (ready_mode)
            0:       tx_ready = 1'b1;
            1:       tx_ready = ~tx_ready;
            default: tx_ready = 1'($urandom_range(0, 1));
        endcase
    end

    // Monitor: a beat is committed when valid && ready is seen before the next edge.
    logic        hold_v = 1'b0, hold_l = 1'b0, busy_prev = 1'b0;
    logic [31:0] hold_d = '0;
    always @(negedge clk) begin
        cyc++;
        if (hold_v) begin
            chk("hold_valid", 64'(tx_valid), 64'd1);
            chk("hold_data", 64'(tx_data), 64'(hold_d));
            chk("hold_last", 64'(tx_last), 64'(hold_l));
        end
        hold_v = 1'b0;
        if (burst_done) begin
            bd_seen++;
            bd_cyc = cyc;
        end
        if (busy_prev && !busy) idle_cyc = cyc;
        busy_prev = busy;
        if (tx_valid && !glbl_rst) begin
            if (tx_ready) begin
                hs_cyc[int'(tx_data)] = cyc;
                beats_seen++;
                $display("beat data=%0d last=%0d cycle=%0d", tx_data, tx_last, cyc);
                if (exp_q.size() == 0) begin
                    checks++;
                    errors++;
                    $display("FAIL unexpected_beat: got data %0d, required no beat", tx_data);
                end else begin
                    mon_e = exp_q.pop_front();
                    chk("beat_data", 64'(tx_data), 64'(mon_e.data));
                    chk("beat_last", 64'(tx_last), 64'(mon_e.last));
                end
            end else begin
                hold_v = 1'b1;
                hold_d = tx_data;
                hold_l = tx_last;
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_cfg(input int w, input int p, input int pz);
        pkt_words      = LEN_W'(w);
        pkts_per_burst = CNT_W'(p);
        pause_cycles   = PAUSE_W'(pz);
    endtask

    // Model: a burst is pkts packets of w words; n_done packets actually complete.
    task automatic push_burst(input int w, input int n_done);
        beat_t b;
        for (int i = 0; i < n_done; i++) begin
            for (int j = 0; j < w; j++) begin
                b.data = exp_data;
                b.last = (j == w - 1);
                exp_q.push_back(b);
                exp_data  = exp_data + 32'd1;
                exp_words = exp_words + 1;
            end
        end
        exp_pkts = exp_pkts + n_done;
    endtask

    task automatic pulse_start();
        start = 1'b1;
        tick();
        start = 1'b0;
    endtask

    task automatic wait_beats(input int target);
        int i;
        for (i = 0; i < 3000 && beats_seen < target; i++) tick();
        if (beats_seen < target) chk("wait_beats_timeout", 64'(beats_seen), 64'(target));
    endtask

    task automatic wait_idle(input string name);
        int i;
        for (i = 0; i < 3000 && busy; i++) tick();
        if (busy) chk("idle_timeout", 64'(busy), 64'd0);
        tick();
        tick();
        $display("scenario %s done: beats=%0d burst_done=%0d", name, beats_seen, bd_seen);
        chk("queue_empty", 64'(exp_q.size()), 64'd0);
        chk("burst_done_count", 64'(bd_seen), 64'(exp_bd));
`ifdef TX_STREAM_SEQ_STATS_EN
        chk("pkt_count", 64'(pkt_count), 64'(exp_pkts));
        chk("word_count", 64'(word_count), 64'(exp_words));
`endif
    endtask

    initial begin
        int s, b, w, p, pz, n, pk;
        bit do_stop;

        repeat (3) tick();
        chk("rst_valid", 64'(tx_valid), 64'd0);
        chk("rst_data", 64'(tx_data), 64'd0);
        chk("rst_last", 64'(tx_last), 64'd0);
        chk("rst_busy", 64'(busy), 64'd0);
        chk("rst_burst_done", 64'(burst_done), 64'd0);
        glbl_rst = 1'b0;
        tick();

        // Single burst, always ready: timing of burst_done and the pause.
        ready_mode = 0;
        set_cfg(4, 2, 10);
        hs_cyc.delete();
        push_burst(4, 2);
        exp_bd++;
        pulse_start();
        wait_idle("basic");
        chk("burst_done_timing", 64'(bd_cyc - hs_cyc[7]), 64'd1);
        chk("pause_then_idle", 64'(idle_cyc - hs_cyc[7]), 64'd11);

        // Backpressure: ready alternating, outputs must hold.
        ready_mode = 1;
        push_burst(4, 2);
        exp_bd++;
        pulse_start();
        wait_idle("alt_ready");

        // Start held: repeating bursts with a 3-cycle gap.
        ready_mode = 0;
        set_cfg(4, 2, 3);
        b = int'(exp_data);
        s = beats_seen;
        push_burst(4, 4);
        exp_bd += 2;
        start = 1'b1;
        wait_beats(s + 9);
        start = 1'b0;
        wait_idle("repeat_pause3");
        chk("burst_gap", 64'(hs_cyc[b + 8] - hs_cyc[b + 7]), 64'd4);

        // Start held, zero pause: bursts back to back.
        set_cfg(3, 1, 0);
        b = int'(exp_data);
        s = beats_seen;
        push_burst(3, 2);
        exp_bd += 2;
        start = 1'b1;
        wait_beats(s + 4);
        start = 1'b0;
        wait_idle("back_to_back");
        chk("no_bubble", 64'(hs_cyc[b + 3] - hs_cyc[b + 2]), 64'd1);

        // Stop mid-packet: packet completes, no burst_done.
        set_cfg(4, 2, 10);
        s = beats_seen;
        push_burst(4, 1);
        pulse_start();
        wait_beats(s + 2);
        stop = 1'b1;
        tick();
        stop = 1'b0;
        wait_idle("stop");

        // Zero configuration never leaves IDLE.
        for (int k = 0; k < 2; k++) begin
            if (k == 0) set_cfg(0, 2, 1);
            else        set_cfg(4, 0, 1);
            start = 1'b1;
            for (int i = 0; i < 12; i++) begin
                tick();
                chk("zero_cfg_valid", 64'(tx_valid), 64'd0);
                chk("zero_cfg_busy", 64'(busy), 64'd0);
            end
            start = 1'b0;
        end
        tick();

        // Randomized bursts with random ready, optional stop and config churn.
        ready_mode = 2;
        for (int it = 0; it < 12; it++) begin
            w  = int'($urandom_range(1, 5));
            p  = int'($urandom_range(1, 3));
            pz = int'($urandom_range(0, 4));
            do_stop = (w >= 2) && ($urandom_range(0, 1) == 1);
            set_cfg(w, p, pz);
            s = beats_seen;
            if (do_stop) begin
                pk = int'($urandom_range(0, p - 1));
                n  = pk * w + int'($urandom_range(0, w - 2));
                push_burst(w, pk + 1);
            end else begin
                n = 0;
                push_burst(w, p);
                exp_bd++;
            end
            $display("random burst %0d: words=%0d pkts=%0d pause=%0d stop=%0d at %0d", it, w, p, pz, do_stop, n);
            pulse_start();
            set_cfg(int'($urandom_range(0, 7)), int'($urandom_range(0, 7)), int'($urandom_range(0, 7)));
            if (do_stop) begin
                wait_beats(s + n);
                stop = 1'b1;
                tick();
                stop = 1'b0;
            end
            wait_idle("random");
        end

        // Reset mid-packet: abandon frame, restart from data 0.
        ready_mode = 0;
        set_cfg(4, 2, 10);
        s = beats_seen;
        push_burst(4, 2);
        pulse_start();
        wait_beats(s + 5);
        glbl_rst = 1'b1;
        tick();
        chk("midrst_valid", 64'(tx_valid), 64'd0);
        chk("midrst_data", 64'(tx_data), 64'd0);
        chk("midrst_busy", 64'(busy), 64'd0);
`ifdef TX_STREAM_SEQ_STATS_EN
        chk("midrst_pkt_count", 64'(pkt_count), 64'd0);
        chk("midrst_word_count", 64'(word_count), 64'd0);
`endif
        exp_q.delete();
        exp_data  = '0;
        exp_words = 0;
        exp_pkts  = 0;
        glbl_rst  = 1'b0;
        tick();
        set_cfg(2, 1, 0);
        push_burst(2, 1);
        exp_bd++;
        pulse_start();
        wait_idle("after_reset");

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation exceeded time limit");
        $fatal(1, "watchdog");
    end

endmodule
